// File: rtl/tm_cfg_sequencer.sv
// tm_cfg_sequencer: front end for the Tsetlin-machine inference core.
// Loads the exclude bank over a valid/ready stream, registers feature
// vectors for the core and tracks each one through the core latency to
// emit a registered class result with a single-cycle valid pulse.
module tm_cfg_sequencer #(
  parameter int NUM_WORDS = 12,
  parameter int WORD_W    = 18,
  parameter int FEAT_W    = 9,
  parameter int CLASS_W   = 2,
  parameter int INF_LAT   = 0
) (
  input  logic                              clk1,
  input  logic                              rst,
  input  logic                              load_start,
  input  logic                              ld_valid,
  input  logic [WORD_W-1:0]                 ld_data,
  output logic                              ld_ready,
  output logic [$clog2(NUM_WORDS+1)-1:0]    ld_count,
  output logic                              cfg_done,
  input  logic                              feat_valid,
  input  logic [FEAT_W-1:0]                 feat_data,
  output logic                              feat_ready,
  output logic [FEAT_W-1:0]                 feat_q,
  output logic [NUM_WORDS*WORD_W-1:0]       ex_bank,
  input  logic [CLASS_W-1:0]                class_in,
  output logic                              res_valid,
  output logic [CLASS_W-1:0]                res_class
);

  localparam int CNT_W  = $clog2(NUM_WORDS + 1);
  localparam int PIPE_D = INF_LAT + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              ld_hs;
  logic              feat_hs;
  logic              last_word;
  logic              flush;
  logic [PIPE_D-1:0] vpipe;

  assign ld_hs     = ld_valid & ld_ready;
  assign feat_hs   = feat_valid & feat_ready;
  assign last_word = (ld_count == CNT_W'(NUM_WORDS - 1));
  assign flush     = (state_q == RUN) && load_start;

  // State register; reset drops straight back to IDLE from anywhere
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake readiness; a load request always blocks the coincident word or feature
  always_comb begin
    state_d    = state_q;
    ld_ready   = 1'b0;
    feat_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_start) state_d = LOAD;
      end
      LOAD: begin
        ld_ready = !load_start;
        if (!load_start && ld_valid && last_word) state_d = RUN;
      end
      RUN: begin
        feat_ready = !load_start;
        if (load_start) state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  // Word counter and config-done flag; any load request restarts counting from zero
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      ld_count <= '0;
      cfg_done <= 1'b0;
    end else if (load_start) begin
      ld_count <= '0;
      cfg_done <= 1'b0;
    end else if (ld_hs) begin
      ld_count <= ld_count + CNT_W'(1);
      if (last_word) cfg_done <= 1'b1;
    end
  end

  // Exclude bank; only the word addressed by the counter changes on a load handshake
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      ex_bank <= '0;
    end else if (ld_hs) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        if (ld_count == CNT_W'(i)) ex_bank[i*WORD_W +: WORD_W] <= ld_data;
      end
    end
  end

  // Feature register toward the core; holds when nothing is accepted
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst)          feat_q <= '0;
    else if (feat_hs) feat_q <= feat_data;
  end

  // Valid shift register matching the core latency; cleared when a reload aborts RUN
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst)        vpipe <= '0;
    else if (flush) vpipe <= '0;
    else            vpipe <= PIPE_D'({vpipe, feat_hs});
  end

  // Result register; captures the core class as the tracked valid bit emerges
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_class <= '0;
    end else if (flush) begin
      res_valid <= 1'b0;
    end else begin
      res_valid <= vpipe[INF_LAT];
      if (vpipe[INF_LAT]) res_class <= class_in;
    end
  end

endmodule

// File: tb/tb_tm_cfg_sequencer.sv
// Testbench for tm_cfg_sequencer with a two-stage core model (INF_LAT=2).
module tb_tm_cfg_sequencer;

  localparam int NW   = 12;
  localparam int WW   = 18;
  localparam int FW   = 9;
  localparam int CW   = 2;
  localparam int LAT  = 2;
  localparam int CNTW = $clog2(NW + 1);

  logic               clk1 = 1'b0;
  logic               rst = 1'b1;
  logic               load_start = 1'b0;
  logic               ld_valid = 1'b0;
  logic [WW-1:0]      ld_data = '0;
  logic               ld_ready;
  logic [CNTW-1:0]    ld_count;
  logic               cfg_done;
  logic               feat_valid = 1'b0;
  logic [FW-1:0]      feat_data = '0;
  logic               feat_ready;
  logic [FW-1:0]      feat_q;
  logic [NW*WW-1:0]   ex_bank;
  logic [CW-1:0]      class_in;
  logic               res_valid;
  logic [CW-1:0]      res_class;

  logic [CW-1:0]      core_s1;
  logic [CW-1:0]      core_s2;

  int                 tests = 0;
  int                 fails = 0;
  int                 cyc = 0;

  int                 m_mode;
  int                 m_cnt;
  logic               m_done;
  logic [WW-1:0]      m_bank [NW];
  logic [FW-1:0]      m_featq;
  logic [CW-1:0]      m_res_class;
  logic               m_res_valid;
  int                 due_q[$];
  logic [CW-1:0]      cls_q[$];

  tm_cfg_sequencer #(
    .NUM_WORDS(NW), .WORD_W(WW), .FEAT_W(FW), .CLASS_W(CW), .INF_LAT(LAT)
  ) dut (
    .clk1(clk1), .rst(rst), .load_start(load_start),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .ld_count(ld_count), .cfg_done(cfg_done),
    .feat_valid(feat_valid), .feat_data(feat_data), .feat_ready(feat_ready),
    .feat_q(feat_q), .ex_bank(ex_bank), .class_in(class_in),
    .res_valid(res_valid), .res_class(res_class)
  );

  // Free-running clock
  always #5 clk1 = ~clk1;

  // Core model: two register stages, class = low bits of the feature vector
  always @(posedge clk1) begin
    core_s1 <= feat_q[CW-1:0];
    core_s2 <= core_s1;
  end
  assign class_in = core_s2;

  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [NW*WW-1:0] flatBank();
    logic [NW*WW-1:0] f;
    f = '0;
    for (int i = 0; i < NW; i++) f[i*WW +: WW] = m_bank[i];
    return f;
  endfunction

  task automatic modelReset();
    m_mode = 0;
    m_cnt = 0;
    m_done = 1'b0;
    for (int i = 0; i < NW; i++) m_bank[i] = '0;
    m_featq = '0;
    m_res_class = '0;
    m_res_valid = 1'b0;
    due_q.delete();
    cls_q.delete();
  endtask

  task automatic checkRegs();
    checkOutput("res_valid", res_valid, m_res_valid);
    checkOutput("res_class", res_class, m_res_class);
    checkOutput("cfg_done",  cfg_done,  m_done);
    checkOutput("ld_count",  ld_count,  m_cnt);
    checkOutput("feat_q",    feat_q,    m_featq);
    checkOutput("ex_bank",   ex_bank,   flatBank());
  endtask

  // One clock of stimulus; model is advanced from the rules, outputs checked after the edge
  task automatic applyStimulus(input logic ls, input logic lv, input logic [WW-1:0] ld,
                               input logic fv, input logic [FW-1:0] fd);
    load_start = ls;
    ld_valid   = lv;
    ld_data    = ld;
    feat_valid = fv;
    feat_data  = fd;
    #1;
    checkOutput("ld_ready",   ld_ready,   (m_mode == 1) && !ls);
    checkOutput("feat_ready", feat_ready, (m_mode == 2) && !ls);
    case (m_mode)
      0: if (ls) begin m_mode = 1; m_cnt = 0; end
      1: begin
        if (ls) m_cnt = 0;
        else if (lv) begin
          m_bank[m_cnt] = ld;
          m_cnt++;
          if (m_cnt == NW) begin m_mode = 2; m_done = 1'b1; end
        end
      end
      default: begin
        if (ls) begin
          m_mode = 1; m_done = 1'b0; m_cnt = 0;
          due_q.delete(); cls_q.delete();
        end else if (fv) begin
          m_featq = fd;
          due_q.push_back(cyc + 1 + LAT + 1);
          cls_q.push_back(fd[CW-1:0]);
        end
      end
    endcase
    @(posedge clk1);
    cyc++;
    #1;
    m_res_valid = 1'b0;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      m_res_valid = 1'b1;
      m_res_class = cls_q.pop_front();
      void'(due_q.pop_front());
    end
    checkRegs();
    @(negedge clk1);
  endtask

  // Asynchronous reset pulse; outputs must clear before any clock edge
  task automatic doReset();
    load_start = 1'b0; ld_valid = 1'b0; feat_valid = 1'b0;
    rst = 1'b1;
    #1;
    modelReset();
    checkRegs();
    checkOutput("rst_ld_ready",   ld_ready,   1'b0);
    checkOutput("rst_feat_ready", feat_ready, 1'b0);
    @(posedge clk1);
    cyc++;
    @(negedge clk1);
    rst = 1'b0;
  endtask

  task automatic loadAll(input logic [WW-1:0] val);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
    for (int k = 0; k < NW; k++) applyStimulus(1'b0, 1'b1, val, 1'b0, '0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, WW'($urandom), 1'b0, FW'($urandom));
  endtask

  initial begin
    modelReset();
    @(negedge clk1);
    doReset();

    // Features ignored in IDLE
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 9'h1FF);

    // Contiguous load of 1..12
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
    for (int k = 0; k < NW; k++) applyStimulus(1'b0, 1'b1, WW'(k + 1), 1'b0, '0);
    idle(1);

    // Reload with ld_valid toggling
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
    for (int k = 0; k < 2 * NW; k++) begin
      if (k % 2 == 0) applyStimulus(1'b0, 1'b1, WW'(k / 2 + 1), 1'b0, '0);
      else            applyStimulus(1'b0, 1'b0, WW'($urandom), 1'b0, '0);
    end

    // Back-to-back features
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 9'h1A5);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 9'h0F3);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 9'h155);
    idle(5);

    // Reload while two features are in flight
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 9'h002);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 9'h003);
    applyStimulus(1'b1, 1'b0, '0, 1'b1, 9'h001);
    for (int k = 0; k < NW; k++) applyStimulus(1'b0, 1'b1, 18'h3FFFF, 1'b0, '0);
    idle(4);

    // Restart coinciding with a word at index 5
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
    for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b1, WW'(16 + k), 1'b0, '0);
    applyStimulus(1'b1, 1'b1, 18'h12345, 1'b0, '0);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, WW'(32 + k), 1'b0, '0);
    idle(2);
    for (int k = 3; k < NW; k++) applyStimulus(1'b0, 1'b1, WW'(32 + k), 1'b0, '0);

    // Reset mid-load at word 7
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
    for (int k = 0; k < 7; k++) applyStimulus(1'b0, 1'b1, WW'($urandom), 1'b0, '0);
    doReset();
    applyStimulus(1'b0, 1'b1, WW'($urandom), 1'b1, 9'h0AA);

    // Reset mid-inference
    loadAll(18'h2AAAA);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 9'h0C7);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 9'h0B6);
    doReset();
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 9'h0AB);
    idle(3);

    // Randomized traffic
    loadAll(WW'($urandom));
    for (int k = 0; k < 600; k++) begin
      applyStimulus(($urandom_range(0, 39) == 0), 1'($urandom), WW'($urandom),
                    1'($urandom), FW'($urandom));
    end
    idle(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
